wb_regfile: RTL and testbench

Writeback stage and register file for the five-stage MIPS pipeline: consumes the MEM/WB pipeline register outputs (ALU result, memory word, destination, opcode, control signals). It selects and extends the result, writes the 32×32 architectural register file, and serves two decode-stage read ports with same-cycle write bypass. It also keeps a retired-instruction counter for the testbench and debug.

---
 rtl/mips_pkg.sv | 14 +
 rtl/wb_regfile_load_extend.sv | 31 +++
 rtl/wb_regfile.sv | 77 +++++++
 tb/tb_wb_regfile.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load opcodes and control-signal bit positions.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam int SIG_REG_WRITE  = 0;
  localparam int SIG_MEM_TO_REG = 1;
  localparam int SIG_VALID      = 7;

endpackage

// File: rtl/wb_regfile_load_extend.sv
// Load extraction: picks the addressed byte/halfword of a little-endian word and extends it.
// Purely combinational, zero latency; no flow control.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword loads take the upper or lower half only; offset[0] is ignored.
    half_sel = word[{offset[1], 4'b0000} +: 16];
    result   = word;
    case (op)
      OP_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
      OP_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file with two bypassed read ports and a retired counter.
// Writes land on the edge ending the cycle (bypass same cycle); no backpressure.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [DATA_W-1:0]        mem_out,
  input  logic [$clog2(REG_N)-1:0] dest_out,
  input  logic [5:0]               op_out,
  input  logic [7:0]               signals_out,
  input  logic [$clog2(REG_N)-1:0] rs_addr,
  input  logic [$clog2(REG_N)-1:0] rt_addr,
  output logic [DATA_W-1:0]        rs_data,
  output logic [DATA_W-1:0]        rt_data,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_we,
  output logic [DATA_W-1:0]        retired
);

  logic              valid;
  logic              reg_write;
  logic              mem_to_reg;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [DATA_W-1:0] retired_q;
  logic [DATA_W-1:0] retired_d;
  logic              unused_sig_bits;

  assign valid           = signals_out[SIG_VALID];
  assign reg_write       = signals_out[SIG_REG_WRITE];
  assign mem_to_reg      = signals_out[SIG_MEM_TO_REG];
  assign unused_sig_bits = ^signals_out[6:2];

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .op     (op_out),
    .offset (alu_out[1:0]),
    .word   (mem_out),
    .result (load_data)
  );

  assign wb_data = mem_to_reg ? load_data : alu_out;
  assign wb_we   = valid & reg_write & (dest_out != '0);
  assign retired = retired_q;

  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[dest_out] = wb_data;
    retired_d = retired_q + {{(DATA_W-1){1'b0}}, valid};
  end

  // r0 reads as zero; a same-cycle write to the indexed register wins over storage.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == '0) rs_data = '0;
    else if (wb_we && rs_addr == dest_out) rs_data = wb_data;
    rt_data = regs_q[rt_addr];
    if (rt_addr == '0) rt_data = '0;
    else if (wb_we && rt_addr == dest_out) rt_data = wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued when stimulus is driven and popped on sampling.
module tb_wb_regfile;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_out, mem_out;
  logic [4:0]  dest_out, rs_addr, rt_addr;
  logic [5:0]  op_out;
  logic [7:0]  signals_out;
  logic [31:0] rs_data, rt_data, wb_data, retired;
  logic        wb_we;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_retired = '0;
  logic [31:0] want;

  always #5 clock = ~clock;

  wb_regfile dut (
    .clock(clock), .reset(reset), .alu_out(alu_out), .mem_out(mem_out),
    .dest_out(dest_out), .op_out(op_out), .signals_out(signals_out),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_we(wb_we), .retired(retired)
  );

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [5:0] op,
                       input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] mem);
    signals_out = {v, 5'b00000, m2r, rw};
    op_out      = op;
    dest_out    = dest;
    alu_out     = alu;
    mem_out     = mem;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, OP_LW, 5'd0, 32'h0, 32'h0);
  endtask

  // Advance one clock; the bench's own model of the retired counter follows the edge.
  task automatic tick();
    if (reset) exp_retired = '0;
    else if (signals_out[SIG_VALID]) exp_retired = exp_retired + 32'd1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    rs_addr = '0;
    rt_addr = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front();
      total++;
      if (rs_data !== want) begin bad++; $display("FAIL reset_rs idx=%0d got=%h want=%h", i, rs_data, want); end
      want = exp_q.pop_front();
      total++;
      if (rt_data !== want) begin bad++; $display("FAIL reset_rt idx=%0d got=%h want=%h", 31 - i, rt_data, want); end
    end
    total++;
    if (retired !== 32'h0) begin bad++; $display("FAIL reset_retired got=%h want=0", retired); end
    tick();
  endtask

  task automatic test_write_bypass();
    // Load opcode with mem_to_reg=0 must still select alu_out.
    drive(1'b1, 1'b1, 1'b0, OP_LB, 5'd5, 32'hDEADBEEF, 32'h11111111);
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    #1;
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL bypass_rs got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (rt_data !== want) begin bad++; $display("FAIL bypass_rt_other got=%h want=%h", rt_data, want); end
    want = exp_q.pop_front();
    total++;
    if ({31'b0, wb_we} !== want) begin bad++; $display("FAIL bypass_we got=%b want=%h", wb_we, want); end
    tick();
    idle();
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL stored_r5 got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL write_retired got=%h want=%h", retired, want); end
    tick();
  endtask

  task automatic test_loads();
    logic [5:0]  ops  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LH};
    logic [1:0]  offs [6] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3};
    logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01,
                              32'h000080FF, 32'h80FF7F01, 32'hFFFF80FF};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, ops[i], 5'(10 + i), {30'h100, offs[i]}, 32'h80FF7F01);
      rs_addr = 5'(10 + i);
      exp_q.push_back(exps[i]);
      exp_q.push_back(exps[i]);
      #1;
      want = exp_q.pop_front();
      total++;
      if (wb_data !== want) begin bad++; $display("FAIL load_wb op=%h off=%0d got=%h want=%h", ops[i], offs[i], wb_data, want); end
      want = exp_q.pop_front();
      total++;
      if (rs_data !== want) begin bad++; $display("FAIL load_bypass op=%h got=%h want=%h", ops[i], rs_data, want); end
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      rt_addr = 5'(10 + i);
      exp_q.push_back(exps[i]);
      #1;
      want = exp_q.pop_front();
      total++;
      if (rt_data !== want) begin bad++; $display("FAIL load_stored r%0d got=%h want=%h", 10 + i, rt_data, want); end
      #1;
    end
    tick();
  endtask

  task automatic test_dest_zero();
    drive(1'b1, 1'b1, 1'b0, OP_LW, 5'd0, 32'h12345678, 32'h0);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front();
    total++;
    if ({31'b0, wb_we} !== want) begin bad++; $display("FAIL r0_we got=%b want=%h", wb_we, want); end
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL r0_rs got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (wb_data !== want) begin bad++; $display("FAIL r0_wb_data got=%h want=%h", wb_data, want); end
    want = exp_q.pop_front();
    total++;
    if (rt_data !== want) begin bad++; $display("FAIL r0_rt got=%h want=%h", rt_data, want); end
    tick();
    idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL r0_after got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL r0_retired got=%h want=%h", retired, want); end
    tick();
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b1, 1'b0, OP_LW, 5'd8, 32'h000000AA, 32'h0);
    rs_addr = 5'd8;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h000000AA);
    exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front();
    total++;
    if ({31'b0, wb_we} !== want) begin bad++; $display("FAIL bubble_we got=%b want=%h", wb_we, want); end
    want = exp_q.pop_front();
    total++;
    if (wb_data !== want) begin bad++; $display("FAIL bubble_wb_data got=%h want=%h", wb_data, want); end
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL bubble_rs got=%h want=%h", rs_data, want); end
    tick();
    idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL bubble_no_write got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL bubble_retired got=%h want=%h", retired, want); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h1, 32'h2, 32'h2};
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 1'b1, 1'b0, OP_LW, 5'd7, vals[i], 32'h0);
      else idle();
      exp_q.push_back(vals[i]);
      exp_q.push_back(vals[i]);
      #1;
      want = exp_q.pop_front();
      total++;
      if (rs_data !== want) begin bad++; $display("FAIL b2b_rs step=%0d got=%h want=%h", i, rs_data, want); end
      want = exp_q.pop_front();
      total++;
      if (rt_data !== want) begin bad++; $display("FAIL b2b_rt step=%0d got=%h want=%h", i, rt_data, want); end
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, OP_LW, 5'd7, 32'h3, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    rt_addr = 5'd5;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (rs_data !== want) begin bad++; $display("FAIL reset_r7 got=%h want=%h", rs_data, want); end
    want = exp_q.pop_front();
    total++;
    if (rt_data !== want) begin bad++; $display("FAIL reset_r5 got=%h want=%h", rt_data, want); end
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL reset_mid_retired got=%h want=%h", retired, want); end
    tick();
  endtask

  task automatic test_wrap();
    idle();
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFFFFFF;
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL wrap_preload got=%h want=%h", retired, want); end
    drive(1'b1, 1'b0, 1'b0, OP_LW, 5'd3, 32'h0, 32'h0);
    tick();
    exp_q.push_back(exp_retired);
    idle();
    tick();
    tick();
    #1;
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL wrap_zero got=%h want=%h", retired, want); end
    drive(1'b1, 1'b0, 1'b0, OP_LW, 5'd3, 32'h0, 32'h0);
    tick();
    idle();
    exp_q.push_back(exp_retired);
    #1;
    want = exp_q.pop_front();
    total++;
    if (retired !== want) begin bad++; $display("FAIL wrap_next got=%h want=%h", retired, want); end
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    rs_addr = '0;
    rt_addr = '0;
    idle();
    @(negedge clock);
    test_reset();
    test_write_bypass();
    test_loads();
    test_dest_zero();
    test_bubble();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
